alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter placing two requesters onto one shared ALU.
// Only one operation is in flight at a time. An accepted request moves through
// ISSUE, then WAIT, then RESP. Each response stays held until its owner consumes it.
module alu_arbiter #(
  parameter int WORD_BITS = 32,
  parameter int TYPE_BITS = 4,
  parameter int OP_BITS   = 6,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,

  // requester 0
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [WORD_BITS-1:0] i_req0_src0,
  input  logic [WORD_BITS-1:0] i_req0_src1,
  input  logic [TYPE_BITS-1:0] i_req0_type,
  input  logic [OP_BITS-1:0]   i_req0_op,
  output logic                 o_rsp0_valid,
  input  logic                 i_rsp0_ready,
  output logic [WORD_BITS-1:0] o_rsp0_result,
  output logic                 o_rsp0_err,

  // requester 1
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [WORD_BITS-1:0] i_req1_src0,
  input  logic [WORD_BITS-1:0] i_req1_src1,
  input  logic [TYPE_BITS-1:0] i_req1_type,
  input  logic [OP_BITS-1:0]   i_req1_op,
  output logic                 o_rsp1_valid,
  input  logic                 i_rsp1_ready,
  output logic [WORD_BITS-1:0] o_rsp1_result,
  output logic                 o_rsp1_err,

  // shared ALU
  output logic [WORD_BITS-1:0] o_alu_operand_0_val,
  output logic [WORD_BITS-1:0] o_alu_operand_1_val,
  output logic [TYPE_BITS-1:0] o_alu_type,
  output logic [OP_BITS-1:0]   o_alu_op,
  output logic                 o_alu_calc_start,
  input  logic [WORD_BITS-1:0] i_alu_result_val,
  input  logic                 i_alu_result_valid,

  output logic                 o_busy
);

  // The wait counter only has to reach TIMEOUT-1. The last WAIT cycle is the one
  // where the counter holds that value.
  localparam int CNT_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_BITS-1:0] LAST_WAIT = CNT_BITS'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic                 prio;        // preferred requester when both are valid
  logic                 owner;       // requester of the op in flight
  logic [WORD_BITS-1:0] src0_q;
  logic [WORD_BITS-1:0] src1_q;
  logic [TYPE_BITS-1:0] type_q;
  logic [OP_BITS-1:0]   op_q;
  logic [CNT_BITS-1:0]  wait_cnt;
  logic [1:0][WORD_BITS-1:0] result_q;  // one result register per requester
  logic [1:0]           err_q;

  logic grant_valid;
  logic grant;
  logic accept;
  logic alu_done;
  logic timeout_hit;
  logic rsp_done;
  logic drive_alu;

  // Round-robin grant: prio breaks a tie; a lone valid requester always wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_valid = 1'b1;
      grant       = prio;
    end else if (i_req0_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (i_req1_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  assign o_req0_ready = (state == IDLE) && grant_valid && (grant == 1'b0);
  assign o_req1_ready = (state == IDLE) && grant_valid && (grant == 1'b1);

  // A ready is only raised toward a valid requester, so any grant in IDLE is a handshake.
  assign accept      = (state == IDLE) && grant_valid;
  assign alu_done    = (state == WAIT) && i_alu_result_valid;
  assign timeout_hit = (state == WAIT) && !i_alu_result_valid && (wait_cnt == LAST_WAIT);
  assign rsp_done    = (state == RESP) && (owner ? i_rsp1_ready : i_rsp0_ready);

  // Next-state logic and the one-cycle ALU start pulse.
  always_comb begin
    state_next       = state;
    o_alu_calc_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        o_alu_calc_start = 1'b1;
        state_next       = WAIT;
      end
      WAIT: begin
        if (alu_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the winning request's operands and owner on the handshake.
  always_ff @(posedge clk) begin
    // NOTE: these are plain flops, not a memory array, so they are cleared on reset to keep ALU outputs defined.
    if (rst) begin
      owner  <= 1'b0;
      src0_q <= '0;
      src1_q <= '0;
      type_q <= '0;
      op_q   <= '0;
    end else if (accept) begin
      owner  <= grant;
      src0_q <= grant ? i_req1_src0 : i_req0_src0;
      src1_q <= grant ? i_req1_src1 : i_req0_src1;
      type_q <= grant ? i_req1_type : i_req0_type;
      op_q   <= grant ? i_req1_op   : i_req0_op;
    end
  end

  // Count WAIT cycles; cleared while the op is being issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT) && !alu_done && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Completion: store the ALU result, or 0 with err set on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= '0;
    end else if (alu_done) begin
      result_q[owner] <= i_alu_result_val;
      err_q[owner]    <= 1'b0;
    end else if (timeout_hit) begin
      result_q[owner] <= '0;
      err_q[owner]    <= 1'b1;
    end
  end

  // The tie-break passes to the other requester once a response is consumed.
  always_ff @(posedge clk) begin
    if (rst)           prio <= 1'b0;
    else if (rsp_done) prio <= ~owner;
  end

  // The ALU side only sees the latched op while it is being issued or awaited.
  assign drive_alu           = (state == ISSUE) || (state == WAIT);
  assign o_alu_operand_0_val = drive_alu ? src0_q : '0;
  assign o_alu_operand_1_val = drive_alu ? src1_q : '0;
  assign o_alu_type          = drive_alu ? type_q : '0;
  assign o_alu_op            = drive_alu ? op_q   : '0;

  // Each response port shows only its owner's pending completion.
  assign o_rsp0_valid  = (state == RESP) && (owner == 1'b0);
  assign o_rsp1_valid  = (state == RESP) && (owner == 1'b1);
  assign o_rsp0_result = o_rsp0_valid ? result_q[0] : '0;
  assign o_rsp1_result = o_rsp1_valid ? result_q[1] : '0;
  assign o_rsp0_err    = o_rsp0_valid & err_q[0];
  assign o_rsp1_err    = o_rsp1_valid & err_q[1];

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus for alu_arbiter (TIMEOUT=4).
// A transaction-level model tracks the age and completion of each op.
// It is compared against every DUT output on each falling edge.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int OW = 6;
  localparam int TO = 4;

  logic          clk;
  logic          rst;
  logic          i_req0_valid, i_req1_valid;
  logic          o_req0_ready, o_req1_ready;
  logic [W-1:0]  i_req0_src0, i_req0_src1, i_req1_src0, i_req1_src1;
  logic [TW-1:0] i_req0_type, i_req1_type;
  logic [OW-1:0] i_req0_op, i_req1_op;
  logic          o_rsp0_valid, o_rsp1_valid;
  logic          i_rsp0_ready, i_rsp1_ready;
  logic [W-1:0]  o_rsp0_result, o_rsp1_result;
  logic          o_rsp0_err, o_rsp1_err;
  logic [W-1:0]  o_alu_operand_0_val, o_alu_operand_1_val;
  logic [TW-1:0] o_alu_type;
  logic [OW-1:0] o_alu_op;
  logic          o_alu_calc_start;
  logic [W-1:0]  i_alu_result_val;
  logic          i_alu_result_valid;
  logic          o_busy;

  alu_arbiter #(.WORD_BITS(W), .TYPE_BITS(TW), .OP_BITS(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_src0(i_req0_src0), .i_req0_src1(i_req0_src1),
    .i_req0_type(i_req0_type), .i_req0_op(i_req0_op),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_result(o_rsp0_result), .o_rsp0_err(o_rsp0_err),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_src0(i_req1_src0), .i_req1_src1(i_req1_src1),
    .i_req1_type(i_req1_type), .i_req1_op(i_req1_op),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_result(o_rsp1_result), .o_rsp1_err(o_rsp1_err),
    .o_alu_operand_0_val(o_alu_operand_0_val), .o_alu_operand_1_val(o_alu_operand_1_val),
    .o_alu_type(o_alu_type), .o_alu_op(o_alu_op), .o_alu_calc_start(o_alu_calc_start),
    .i_alu_result_val(i_alu_result_val), .i_alu_result_valid(i_alu_result_valid),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_age counts edges since acceptance. Age 1 is the issue cycle, and ages 2.. are
  // waiting cycles. m_done marks a completion that has not yet been consumed.
  bit            model_on = 1'b0;
  bit            m_busy, m_done, m_owner, m_prio, m_err;
  int            m_age;
  logic [W-1:0]  m_src0, m_src1, m_res;
  logic [TW-1:0] m_type;
  logic [OW-1:0] m_op;

  function automatic int pick(input logic v0, input logic v1, input bit p);
    if (v0 && v1) return p ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (rst) begin
      model_on = 1'b1;
      m_busy = 0; m_done = 0; m_prio = 0; m_age = 0; m_owner = 0;
    end else if (!m_busy) begin
      w = pick(i_req0_valid, i_req1_valid, m_prio);
      if (w >= 0) begin
        m_busy = 1; m_done = 0; m_age = 1; m_owner = (w == 1);
        m_src0 = m_owner ? i_req1_src0 : i_req0_src0;
        m_src1 = m_owner ? i_req1_src1 : i_req0_src1;
        m_type = m_owner ? i_req1_type : i_req0_type;
        m_op   = m_owner ? i_req1_op   : i_req0_op;
      end
    end else if (!m_done) begin
      if (m_age >= 2) begin
        if (i_alu_result_valid) begin
          m_done = 1; m_res = i_alu_result_val; m_err = 0;
        end else if (m_age - 1 == TO) begin
          m_done = 1; m_res = '0; m_err = 1;
        end
      end
      m_age++;
    end else if (m_owner ? i_rsp1_ready : i_rsp0_ready) begin
      m_busy = 0;
      m_prio = !m_owner;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin : compare
    int  w;
    bit  on_alu, r0, r1;
    if (model_on) begin
      w      = pick(i_req0_valid, i_req1_valid, m_prio);
      on_alu = m_busy && !m_done;
      r0     = m_busy && m_done && !m_owner;
      r1     = m_busy && m_done && m_owner;
      check("req0_ready", o_req0_ready, !m_busy && (w == 0));
      check("req1_ready", o_req1_ready, !m_busy && (w == 1));
      check("busy",       o_busy, m_busy);
      check("calc_start", o_alu_calc_start, on_alu && (m_age == 1));
      check("alu_op0",    o_alu_operand_0_val, on_alu ? m_src0 : '0);
      check("alu_op1",    o_alu_operand_1_val, on_alu ? m_src1 : '0);
      check("alu_type",   o_alu_type, on_alu ? m_type : '0);
      check("alu_op",     o_alu_op, on_alu ? m_op : '0);
      check("rsp0_valid", o_rsp0_valid, r0);
      check("rsp1_valid", o_rsp1_valid, r1);
      check("rsp0_result", o_rsp0_result, r0 ? m_res : '0);
      check("rsp1_result", o_rsp1_result, r1 ? m_res : '0);
      check("rsp0_err",   o_rsp0_err, r0 && m_err);
      check("rsp1_err",   o_rsp1_err, r1 && m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req0 alone and count cycles from its handshake to rsp0_valid.
  task automatic measure_req0(output int lat);
    i_req0_valid = 1'b1;
    @(negedge clk);
    check("lat_ready0", o_req0_ready, 1'b1);
    tick();
    i_req0_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (o_rsp0_valid) break;
      tick();
      lat++;
    end
  endtask

  task automatic wait_rsp(input bit which, output bit found);
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (which ? o_rsp1_valid : o_rsp0_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!o_busy) break;
      tick();
    end
    check("drain_idle", o_busy, 1'b0);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int         lat;
    bit         found;
    logic [2:0] exp_order;

    rst = 1'b1;
    i_req0_valid = 0; i_req1_valid = 0;
    i_req0_src0 = 0; i_req0_src1 = 0; i_req0_type = 0; i_req0_op = 0;
    i_req1_src0 = 32'h1111_0000; i_req1_src1 = 32'h2222_0000; i_req1_type = 4'd9; i_req1_op = 6'd33;
    i_rsp0_ready = 0; i_rsp1_ready = 0;
    i_alu_result_val = 0; i_alu_result_valid = 0;

    // reset state
    tick(); tick();
    @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_rsp0_valid", o_rsp0_valid, 1'b0);
    check("rst_calc_start", o_alu_calc_start, 1'b0);

    // single op 5+3 with spurious ALU valids in IDLE and ISSUE
    tick();
    rst = 1'b0;
    i_alu_result_valid = 1'b1; i_alu_result_val = 32'd77;
    i_rsp0_ready = 1'b1;   // held high early: no effect until rsp0_valid
    @(negedge clk);
    check("idle_spurious_busy", o_busy, 1'b0);
    tick();
    i_req0_valid = 1'b1; i_req0_src0 = 32'd5; i_req0_src1 = 32'd3; i_req0_type = 4'd1; i_req0_op = 6'd2;
    @(negedge clk);
    check("single_ready0", o_req0_ready, 1'b1);
    tick();                                  // accept edge
    i_req0_valid = 1'b0;
    @(negedge clk);
    check("single_calc_start", o_alu_calc_start, 1'b1);
    check("single_operand0", o_alu_operand_0_val, 32'd5);
    check("single_operand1", o_alu_operand_1_val, 32'd3);
    tick();                                  // first WAIT cycle
    i_alu_result_val = 32'd8;
    @(negedge clk);
    check("single_start_once", o_alu_calc_start, 1'b0);
    check("single_no_early_rsp", o_rsp0_valid, 1'b0);
    tick();                                  // accept + 3
    i_alu_result_valid = 1'b0;
    @(negedge clk);
    check("single_rsp0_valid", o_rsp0_valid, 1'b1);
    check("single_result", o_rsp0_result, 32'd8);
    check("single_err", o_rsp0_err, 1'b0);
    tick();
    @(negedge clk);
    check("single_back_idle", o_busy, 1'b0);

    // contention from reset: expected owner order 0, 1, 0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
    i_alu_result_valid = 1'b1; i_alu_result_val = 32'h1234;
    @(negedge clk);
    check("cont_ready0", o_req0_ready, 1'b1);
    check("cont_ready1", o_req1_ready, 1'b0);
    exp_order = 3'b010;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (o_rsp0_valid || o_rsp1_valid) begin
          found = 1'b1;
          break;
        end
      end
      check("cont_rsp_seen", found, 1'b1);
      check("cont_owner", o_rsp1_valid, exp_order[k]);
      check("cont_result", o_rsp1_valid ? o_rsp1_result : o_rsp0_result, 32'h1234);
    end
    tick();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    wait_idle();

    // backpressure on requester 1
    i_rsp1_ready = 1'b0;
    i_req1_valid = 1'b1;
    i_alu_result_val = 32'hABCD;
    wait_rsp(1'b1, found);
    check("bp_rsp1_seen", found, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      i_req0_valid = 1'b1;
      @(negedge clk);
      check("bp_rsp1_valid", o_rsp1_valid, 1'b1);
      check("bp_rsp1_result", o_rsp1_result, 32'hABCD);
      check("bp_busy", o_busy, 1'b1);
      check("bp_no_grant0", o_req0_ready, 1'b0);
    end
    tick();
    i_rsp1_ready = 1'b1; i_req1_valid = 1'b0;
    @(negedge clk);
    check("bp_release_valid", o_rsp1_valid, 1'b1);
    tick();
    i_rsp1_ready = 1'b0;
    @(negedge clk);
    check("bp_next_grant0", o_req0_ready, 1'b1);
    tick();
    i_req0_valid = 1'b0;
    wait_idle();

    // timeout: ALU never answers, TIMEOUT=4 waiting cycles
    i_alu_result_valid = 1'b0;
    i_req0_src0 = 32'hDEAD_BEEF; i_req0_src1 = 32'h0000_0042; i_req0_type = 4'd3; i_req0_op = 6'd7;
    measure_req0(lat);
    check("to_latency", lat, 2 + TO);
    check("to_result", o_rsp0_result, 32'd0);
    check("to_err", o_rsp0_err, 1'b1);
    tick();
    wait_idle();

    // reset during WAIT, then a late ALU valid
    i_req0_valid = 1'b1;
    @(negedge clk);
    check("rw_ready0", o_req0_ready, 1'b1);
    tick();                                  // accept
    i_req0_valid = 1'b0;
    tick();                                  // into WAIT
    rst = 1'b1;
    @(negedge clk);
    check("rw_busy_in_wait", o_busy, 1'b1);
    tick();                                  // reset edge
    rst = 1'b0;
    i_alu_result_valid = 1'b1; i_alu_result_val = 32'hBAD0;
    @(negedge clk);
    check("rw_idle_after_rst", o_busy, 1'b0);
    check("rw_no_rsp", o_rsp0_valid, 1'b0);
    tick();
    i_alu_result_valid = 1'b0;
    @(negedge clk);
    check("rw_still_idle", o_busy, 1'b0);
    check("rw_still_no_rsp", o_rsp0_valid, 1'b0);
    tick();
    i_alu_result_valid = 1'b1; i_alu_result_val = 32'h55;
    i_req0_src0 = 32'd10; i_req0_src1 = 32'd20;
    measure_req0(lat);
    check("rw_next_latency", lat, 3);
    check("rw_next_result", o_rsp0_result, 32'h55);
    check("rw_next_err", o_rsp0_err, 1'b0);
    tick();
    i_alu_result_valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
